// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between a loopback echo FIFO and four prioritised report requesters.
// Optional CR/LF trailer after each report is enabled by defining UART_TX_CRLF_EN.
module uart_tx_arbiter #(
  parameter int unsigned LOOP_DEPTH  = 4,
  parameter int unsigned MAX_RPT_LEN = 32
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iLoopData,
  input  logic       iLoopValid,
  input  logic       iReqWatch,
  input  logic       iReqSr04,
  input  logic       iReqTemp,
  input  logic       iReqHum,
  output logic [1:0] oRptSel,
  output logic [4:0] oRptIdx,
  input  logic [7:0] iRptByte,
  input  logic       iRptLast,
  output logic [7:0] oTxData,
  output logic       oTxStart,
  input  logic       iTxBusy,
  output logic [3:0] oPending,
  output logic       oBusy,
  output logic       oLoopDrop
);

  localparam int unsigned PW = $clog2(LOOP_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [4:0] IDX_MAX = 5'(MAX_RPT_LEN - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, START, WAIT_ACK, WAIT_DONE
`ifdef UART_TX_CRLF_EN
    , CR, LF
`endif
  } state_t;

  typedef enum logic [1:0] {
    SRC_LOOP, SRC_RPT
`ifdef UART_TX_CRLF_EN
    , SRC_CR, SRC_LF
`endif
  } src_t;

  state_t state, nextState;
  src_t   src;
  logic   fetchWait;
  logic   lastByte;

  logic [7:0]    mem [LOOP_DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;

  logic       anyPend, full, empty, push, pop;
  logic [1:0] selIdx;
  logic [3:0] reqs, clrMask;

  assign reqs    = {iReqHum, iReqTemp, iReqSr04, iReqWatch};
  assign anyPend = |oPending;
  assign full    = (count == CW'(LOOP_DEPTH));
  assign empty   = (count == '0);
  assign pop     = (state == IDLE) && !anyPend && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
  assign push    = iLoopValid && (!full || pop);

  always_comb begin
    selIdx = 2'd0;
    casez (oPending)
      4'b???1: selIdx = 2'd0;
      4'b??10: selIdx = 2'd1;
      4'b?100: selIdx = 2'd2;
      4'b1000: selIdx = 2'd3;
      default: selIdx = 2'd0;
    endcase
  end

  always_comb begin
    clrMask = '0;
    if (state == IDLE && anyPend) clrMask[selIdx] = 1'b1;
  end

  always_ff @(posedge iClk) begin
    if (iRst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (anyPend)     nextState = FETCH;
        else if (!empty) nextState = START;
      end
      FETCH:    if (fetchWait) nextState = START;
      START:    nextState = WAIT_ACK;
      WAIT_ACK: if (iTxBusy) nextState = WAIT_DONE;
      WAIT_DONE: begin
        if (!iTxBusy) begin
          case (src)
            SRC_RPT: begin
              if (!lastByte) nextState = FETCH;
`ifdef UART_TX_CRLF_EN
              else           nextState = CR;
`else
              else           nextState = IDLE;
`endif
            end
`ifdef UART_TX_CRLF_EN
            SRC_CR:  nextState = LF;
`endif
            default: nextState = IDLE;
          endcase
        end
      end
`ifdef UART_TX_CRLF_EN
      CR: nextState = START;
      LF: nextState = START;
`endif
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    oTxStart = (state == START);
    oBusy    = (state != IDLE);
  end

  always_ff @(posedge iClk) begin
    if (push) mem[wrPtr] <= iLoopData;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      oPending  <= '0;
      oLoopDrop <= 1'b0;
      oRptSel   <= '0;
      oRptIdx   <= '0;
      oTxData   <= '0;
      src       <= SRC_LOOP;
      fetchWait <= 1'b0;
      lastByte  <= 1'b0;
    end else begin
      // Set wins over clear so a request during its own report queues a repeat
      oPending  <= (oPending & ~clrMask) | reqs;
      oLoopDrop <= iLoopValid && full && !pop;
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          if (anyPend) begin
            oRptSel   <= selIdx;
            oRptIdx   <= '0;
            src       <= SRC_RPT;
            fetchWait <= 1'b0;
          end else if (pop) begin
            oTxData <= mem[rdPtr];
            src     <= SRC_LOOP;
          end
        end
        FETCH: begin
          // First cycle lets the formatter respond to the new sel/idx
          if (!fetchWait) begin
            fetchWait <= 1'b1;
          end else begin
            fetchWait <= 1'b0;
            oTxData   <= iRptByte;
            lastByte  <= iRptLast || (oRptIdx == IDX_MAX);
          end
        end
        WAIT_DONE: begin
          if (!iTxBusy) begin
            if (src == SRC_RPT && !lastByte && oRptIdx != IDX_MAX)
              oRptIdx <= oRptIdx + 5'd1;
`ifdef UART_TX_CRLF_EN
            if (src == SRC_RPT && lastByte) src <= SRC_CR;
            else if (src == SRC_CR)         src <= SRC_LF;
`endif
          end
        end
`ifdef UART_TX_CRLF_EN
        CR: oTxData <= 8'h0D;
        LF: oTxData <= 8'h0A;
`endif
        default: ;
      endcase
    end
  end

endmodule
